serial_adder: RTL
=================

# serial_adder

Parametrised digit-serial adder/subtractor. It is the multi-bit successor to the single-bit full-adder cell, built around one DIGIT-wide carry-propagate slice and a registered carry. It accepts two WIDTH-bit operands through a start/done handshake and processes DIGIT bits per clock, LSB digit first. It returns the sum, carry-out and signed overflow in registered outputs that hold until the next operation.

## Interface

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. WIDTH must be a multiple of DIGIT (elaboration-time check). N = WIDTH/DIGIT.

Ports:
- clk  in  1  clock; rising edge active.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new operation. Sampled only when busy=0.
- sub  in  1  mode, sampled with start. 0 = add, 1 = subtract (a − b).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) or borrow-in (sub), sampled with start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- sum  out  WIDTH  result, registered, held until the next done.
- cout  out  1  raw carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- FSM states: IDLE, RUN, DONE.
- Accept condition: start=1 while the state is IDLE or DONE. On accept:
  - latch a into shift register A.
  - latch b into shift register B: b in add mode, ~b in sub mode.
  - carry register ← cin (add) or ~cin (sub).
  - clear the digit counter; go to RUN.
- RUN, each cycle:
  - Add A[DIGIT-1:0] + B[DIGIT-1:0] + carry using a DIGIT-wide ripple of full-adder slices.
  - Shift A and B right by DIGIT.
  - Shift the DIGIT result bits into the top of the result shift register.
  - carry ← slice carry-out.
  - On the last digit (counter = N−1), also capture the carry into the MSB bit position for overflow.
- Leaving RUN after digit N−1:
  - sum ← result shift register, including the final digit.
  - cout ← final carry; ovf ← carry_into_MSB XOR final carry.
  - go to DONE.
- DONE lasts one cycle and asserts done. Next state: RUN if start=1 (back-to-back accept), else IDLE.
- start is ignored in RUN. Operand, mode and cin inputs are don't-care outside the accept cycle.
- sum, cout and ovf change only on the transition into DONE. They are stable during RUN and hold the previous result.
- Arithmetic is modulo 2^WIDTH. Subtract computes a + ~b + ~cin, i.e. a − b − borrow_in.

## Timing

- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Carry, counter and shift registers are cleared.
- Reset mid-operation aborts the operation; no done pulse follows. Deassertion is synchronised externally; the first accept is possible on the first edge after rst_n rises.
- Latency: start is sampled at edge E0. busy=1 from E0 through E0+N; RUN occupies N cycles. done=1 and the new sum/cout/ovf are visible from edge E0+N for exactly one cycle (done), and the results persist after that.
- busy=0 in the DONE cycle, so a start there is accepted. Back-to-back throughput is one result per N+1 cycles.
- busy and done are never high in the same cycle.
- Digit counter width is clog2(N), minimum 1. With N=1 (DIGIT=WIDTH), RUN lasts one cycle and latency is 1.

## Test plan

- WIDTH=8, DIGIT=1, add 0x7F + 0x01, cin=0 → done 8 cycles after the start edge; sum=0x80, cout=0, ovf=1; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1, add 0xFF + 0x01, cin=0 → sum=0x00, cout=1, ovf=0. Add 0xFF + 0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- WIDTH=8, DIGIT=1, sub 0x05 − 0x07, cin=0 → sum=0xFE, cout=0 (borrow), ovf=0. Sub 0x80 − 0x01, cin=0 → sum=0x7F, cout=1, ovf=1.
- Protocol checks:
  - start held high continuously through an operation → mid-RUN starts are ignored; a second op is accepted in the DONE cycle; its done arrives exactly N+1 cycles after the first done.
  - Prior result holds through the entire second RUN.
- Reset mid-RUN: pulse rst_n low at cycle 3 of an 8-cycle op → all outputs 0 immediately; no done pulse; a fresh 0x12 + 0x34 op then yields sum=0x46.
- WIDTH=16, DIGIT=4 (N=4) → 0x00FF + 0xFF01 gives sum=0x0000, cout=1, ovf=0, done 4 cycles after start. Randomised add/sub sweep matches a golden (a ± b ± cin) model for DIGIT ∈ {1, 2, 4, 16}.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, with a
// registered carry between digits and results held until the next operation.

module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one digit per cycle, N cycles
// DONE  | one-cycle done pulse, new start accepted here
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] slice_sum;
    logic [DIGIT:0]   slice_c;
    logic [WIDTH-1:0] res_shift;

    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign last_digit = (cnt_q == CW'(N - 1));

    // Carry-propagate slice over the low digit of the operand shift registers
    assign slice_c[0] = carry_q;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_slice
            serial_adder_fa u_fa (
                .a_i (a_q[i]),
                .b_i (b_q[i]),
                .c_i (slice_c[i]),
                .s_o (slice_sum[i]),
                .c_o (slice_c[i+1])
            );
        end
    endgenerate

    assign res_shift = WIDTH'({slice_sum, res_q} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Subtraction folds into the adder as a + ~b + ~borrow_in
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? ~cin : cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = slice_c[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last_digit) begin
                sum_d  = res_shift;
                cout_d = slice_c[DIGIT];
                ovf_d  = slice_c[DIGIT] ^ slice_c[DIGIT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
